// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the RV32 MEM stage: load/store/branch funct3 values,
// access FSM states, byte-enable patterns and the sizing helpers built on them.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Size comes from funct3[1:0]; the 011/110/111 encodings are never legal accesses.
    function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~addr_lo[0];
            F3_LW:         ok = (addr_lo == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            F3_SB[1:0]: be = BE_BYTE << addr_lo;
            F3_SH[1:0]: be = BE_HALF << addr_lo;
            F3_SW[1:0]: be = BE_WORD;
            default:    be = BE_WORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge port between the MEM stage and the data memory.
interface memory_access_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_load_extend.sv
// Picks the addressed byte/half lane out of a raw memory word and sign- or
// zero-extends it according to the load funct3.
module mem_load_extend
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data_out
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data_out = rdata;
        case (funct3)
            F3_LB:   data_out = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  data_out = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   data_out = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  data_out = {{(XLEN-16){1'b0}}, half_lane};
            F3_LW:   data_out = rdata;
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the 5-stage RV32 pipeline: resolves branch/jump redirects, runs
// the req/ack data-memory access with a timeout, and loads the MEM/WB register.
module memory_access
    import riscv_mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ctl_MemtoReg_in,
    input  logic             Ctl_RegWrite_in,
    input  logic             Ctl_MemRead_in,
    input  logic             Ctl_MemWrite_in,
    input  logic             Ctl_Branch_in,
    input  logic             jal_in,
    input  logic             jalr_in,
    input  logic             Zero_in,
    input  logic [2:0]       funct3_in,
    input  logic [4:0]       Rd_in,
    input  logic [XLEN-1:0]  ALUresult_in,
    input  logic [XLEN-1:0]  PCimm_in,
    input  logic [XLEN-1:0]  ReadData2_in,
    input  logic [XLEN-1:0]  PC_in,
    memory_access_if.master  dmem,
    output logic             stall_out,
    output logic             PCSrc_out,
    output logic [XLEN-1:0]  PCtarget_out,
    output logic             misalign_err_out,
    output logic             bus_err_out,
    output logic             Ctl_MemtoReg_out,
    output logic             Ctl_RegWrite_out,
    output logic [4:0]       Rd_out,
    output logic [XLEN-1:0]  ReadData_out,
    output logic [XLEN-1:0]  ALUresult_out
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic            mem_op, addr_ok, fault;
    logic            req, stall, abort, complete;
    logic            take, redirect;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] load_data, wb_value, wdata;

    logic            memtoreg_p1, regwrite_p1, misalign_p1, bus_err_p1;
    logic [4:0]      rd_p1;
    logic [XLEN-1:0] rdata_p1, alu_p1;

    // EX/MEM decode: access legality from funct3 size and address low bits
    assign mem_op  = Ctl_MemRead_in | Ctl_MemWrite_in;
    assign addr_lo = ALUresult_in[1:0];
    assign addr_ok = access_ok(funct3_in, addr_lo);
    assign fault   = mem_op & ~addr_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (mem_op && addr_ok && !dmem.ack) begin
                    state_next = ST_BUSY;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_BUSY: begin
                if (dmem.ack || cnt == CNT_MAX) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Reset low masks every combinational control so a pending access drops at once.
    always_comb begin
        req      = 1'b0;
        stall    = 1'b0;
        abort    = 1'b0;
        complete = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    req      = mem_op & addr_ok;
                    complete = req & dmem.ack;
                    stall    = req & ~dmem.ack;
                end
                ST_BUSY: begin
                    req      = 1'b1;
                    complete = dmem.ack;
                    abort    = ~dmem.ack & (cnt == CNT_MAX);
                    stall    = ~dmem.ack & (cnt != CNT_MAX);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (funct3_in[1:0])
            F3_SB[1:0]: wdata = {(XLEN/8){ReadData2_in[7:0]}};
            F3_SH[1:0]: wdata = {(XLEN/16){ReadData2_in[15:0]}};
            default:    wdata = ReadData2_in;
        endcase
    end

    assign dmem.req   = req;
    assign dmem.we    = req & Ctl_MemWrite_in;
    assign dmem.addr  = {ALUresult_in[XLEN-1:2], 2'b00};
    assign dmem.wdata = wdata;
    assign dmem.be    = store_be(funct3_in, addr_lo);

    mem_load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .rdata   (dmem.rdata),
        .addr_lo (addr_lo),
        .funct3  (funct3_in),
        .data_out(load_data)
    );

    assign take         = Ctl_Branch_in & ((funct3_in == F3_BNE) ? ~Zero_in : Zero_in);
    assign redirect     = take | jal_in | jalr_in;
    assign PCSrc_out    = redirect & ~stall & reset;
    assign PCtarget_out = jalr_in ? {ALUresult_in[XLEN-1:1], 1'b0} : PCimm_in;
    assign stall_out    = stall;

    assign wb_value = (jal_in | jalr_in) ? PC_in + XLEN'(4) : ALUresult_in;

    // MEM/WB register (p1): a stalled cycle writes a bubble so WB never repeats
    always_ff @(posedge clk) begin
        if (!reset) begin
            memtoreg_p1 <= 1'b0;
            regwrite_p1 <= 1'b0;
            misalign_p1 <= 1'b0;
            rd_p1       <= '0;
            rdata_p1    <= '0;
            alu_p1      <= '0;
        end else if (!stall) begin
            memtoreg_p1 <= Ctl_MemtoReg_in;
            regwrite_p1 <= Ctl_RegWrite_in & ~fault & ~abort;
            misalign_p1 <= fault;
            rd_p1       <= Rd_in;
            rdata_p1    <= (Ctl_MemRead_in & complete) ? load_data : '0;
            alu_p1      <= wb_value;
        end else begin
            regwrite_p1 <= 1'b0;
            misalign_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_err_p1 <= 1'b0;
        end else if (abort) begin
            bus_err_p1 <= 1'b1;
        end
    end

    assign Ctl_MemtoReg_out = memtoreg_p1;
    assign Ctl_RegWrite_out = regwrite_p1;
    assign misalign_err_out = misalign_p1;
    assign bus_err_out      = bus_err_p1;
    assign Rd_out           = rd_p1;
    assign ReadData_out     = rdata_p1;
    assign ALUresult_out    = alu_p1;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a transaction-level model predicts each
// cycle's bus/stall/redirect outputs and the MEM/WB contents that follow.
module tb_memory_access;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in;
    logic        jal_in, jalr_in, Zero_in;
    logic [2:0]  funct3_in;
    logic [4:0]  Rd_in;
    logic [31:0] ALUresult_in, PCimm_in, ReadData2_in, PC_in;
    logic        stall_out, PCSrc_out, misalign_err_out, bus_err_out;
    logic        Ctl_MemtoReg_out, Ctl_RegWrite_out;
    logic [31:0] PCtarget_out, ReadData_out, ALUresult_out;
    logic [4:0]  Rd_out;

    memory_access_if #(.XLEN(XLEN)) bus ();

    memory_access #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
        .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
        .Ctl_Branch_in(Ctl_Branch_in), .jal_in(jal_in), .jalr_in(jalr_in), .Zero_in(Zero_in),
        .funct3_in(funct3_in), .Rd_in(Rd_in), .ALUresult_in(ALUresult_in), .PCimm_in(PCimm_in),
        .ReadData2_in(ReadData2_in), .PC_in(PC_in), .dmem(bus.master),
        .stall_out(stall_out), .PCSrc_out(PCSrc_out), .PCtarget_out(PCtarget_out),
        .misalign_err_out(misalign_err_out), .bus_err_out(bus_err_out),
        .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
        .Rd_out(Rd_out), .ReadData_out(ReadData_out), .ALUresult_out(ALUresult_out)
    );

    typedef struct {
        logic        mr, mw, br, jal, jalr, zero, m2r, rw;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, pcimm, rs2, pc, rdata;
        int          ack_dly;   // cycles of ack-low before ack; negative = never
    } instr_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en = 1'b0;
    logic        exp_req = 0, exp_we = 0, exp_stall = 0, exp_pcsrc = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0, exp_target = 0;
    logic [3:0]  exp_be = 0;
    logic        exp_rw = 0, exp_m2r = 0, exp_mis = 0, exp_buserr = 0;
    logic [4:0]  exp_rd = 0;
    logic [31:0] exp_alu = 0, exp_rdata = 0;

    logic        obs_req, obs_we, obs_pcsrc;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_target;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic legal_access(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
        return (a % (32'd1 << f3[1:0])) == 0;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] rs2, input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return {24'h0, rs2[7:0]} * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return {16'h0, rs2[15:0]} * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [31:0] a);
        int bytes;
        bytes = 1 << f3[1:0];
        return 4'(((1 << bytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] rdata, input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] v;
        byte         b;
        shortint     h;
        v = rdata >> ((a % 4) * 8);
        b = v[7:0];
        h = v[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b100:  return v & 32'hFF;
            3'b001:  return 32'(h);
            3'b101:  return v & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    function automatic instr_t nop_i();
        instr_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic instr_t mk_load(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [31:0] alu, input logic [31:0] rdata, input int dly);
        instr_t t;
        t = nop_i();
        t.mr = 1; t.m2r = 1; t.rw = 1; t.f3 = f3; t.rd = rd; t.alu = alu; t.rdata = rdata; t.ack_dly = dly;
        return t;
    endfunction

    function automatic instr_t mk_store(input logic [2:0] f3, input logic [31:0] alu,
                                        input logic [31:0] rs2, input int dly);
        instr_t t;
        t = nop_i();
        t.mw = 1; t.f3 = f3; t.alu = alu; t.rs2 = rs2; t.ack_dly = dly;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        Ctl_MemtoReg_in = t.m2r; Ctl_RegWrite_in = t.rw; Ctl_MemRead_in = t.mr; Ctl_MemWrite_in = t.mw;
        Ctl_Branch_in = t.br; jal_in = t.jal; jalr_in = t.jalr; Zero_in = t.zero;
        funct3_in = t.f3; Rd_in = t.rd; ALUresult_in = t.alu; PCimm_in = t.pcimm;
        ReadData2_in = t.rs2; PC_in = t.pc; bus.rdata = t.rdata;
    endtask

    // Plans the whole transaction from the ack delay, then walks it cycle by cycle.
    task automatic issue(input instr_t t, output int stalls);
        logic mem_op, ok, do_req, timed_out, redirect;
        int   ncyc;
        drive(t);
        mem_op    = t.mr | t.mw;
        ok        = !mem_op || legal_access(t.f3, t.alu);
        do_req    = mem_op && ok;
        timed_out = do_req && (t.ack_dly < 0 || t.ack_dly > TIMEOUT);
        ncyc      = !do_req ? 1 : (timed_out ? TIMEOUT + 1 : t.ack_dly + 1);
        redirect  = (t.br && ((t.f3 == 3'b001) ? !t.zero : t.zero)) || t.jal || t.jalr;
        exp_req    = do_req;
        exp_we     = do_req && t.mw;
        exp_addr   = t.alu & ~32'h3;
        exp_wdata  = wdata_model(t.rs2, t.f3);
        exp_be     = be_model(t.f3, t.alu);
        exp_target = t.jalr ? (t.alu & ~32'h1) : t.pcimm;
        stalls = 0;
        for (int k = 0; k < ncyc; k++) begin
            bus.ack   = do_req && !timed_out && (k == t.ack_dly);
            exp_stall = (k < ncyc - 1);
            exp_pcsrc = redirect && !exp_stall;
            chk_en    = 1'b1;
            @(negedge clk);
            if (k == 0) begin
                obs_req = bus.req; obs_we = bus.we; obs_be = bus.be; obs_wdata = bus.wdata;
                obs_pcsrc = PCSrc_out; obs_target = PCtarget_out;
            end
            if (stall_out) stalls++;
            @(posedge clk);
            #1;
            if (exp_stall) begin
                exp_rw  = 1'b0;
                exp_mis = 1'b0;
            end
        end
        chk_en  = 1'b0;
        bus.ack = 1'b0;
        exp_rw    = t.rw && ok && !timed_out;
        exp_m2r   = t.m2r;
        exp_rd    = t.rd;
        exp_alu   = (t.jal || t.jalr) ? t.pc + 32'd4 : t.alu;
        exp_rdata = (t.mr && do_req && !timed_out) ? load_model(t.rdata, t.alu, t.f3) : 32'h0;
        exp_mis   = mem_op && !ok;
        if (timed_out) exp_buserr = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall_out", 32'(stall_out), 32'(exp_stall));
            check("dmem_req", 32'(bus.req), 32'(exp_req));
            if (exp_req) begin
                check("dmem_we", 32'(bus.we), 32'(exp_we));
                check("dmem_addr", bus.addr, exp_addr);
                check("dmem_be", 32'(bus.be), 32'(exp_be));
                if (exp_we) check("dmem_wdata", bus.wdata, exp_wdata);
            end
            check("PCSrc_out", 32'(PCSrc_out), 32'(exp_pcsrc));
            if (exp_pcsrc) check("PCtarget_out", PCtarget_out, exp_target);
            check("RegWrite_out", 32'(Ctl_RegWrite_out), 32'(exp_rw));
            check("MemtoReg_out", 32'(Ctl_MemtoReg_out), 32'(exp_m2r));
            check("Rd_out", 32'(Rd_out), 32'(exp_rd));
            check("ALUresult_out", ALUresult_out, exp_alu);
            check("ReadData_out", ReadData_out, exp_rdata);
            check("misalign_err_out", 32'(misalign_err_out), 32'(exp_mis));
            check("bus_err_out", 32'(bus_err_out), 32'(exp_buserr));
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        instr_t t;
        int     st;
        drive(nop_i());
        bus.ack = 1'b0;
        // Requests and redirects must stay masked while reset is held low.
        Ctl_MemRead_in = 1'b1;
        jal_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst dmem_req", 32'(bus.req), 32'h0);
        check("rst stall_out", 32'(stall_out), 32'h0);
        check("rst PCSrc_out", 32'(PCSrc_out), 32'h0);
        check("rst RegWrite_out", 32'(Ctl_RegWrite_out), 32'h0);
        check("rst ALUresult_out", ALUresult_out, 32'h0);
        check("rst bus_err_out", 32'(bus_err_out), 32'h0);
        drive(nop_i());
        reset = 1'b1;

        issue(mk_load(3'b010, 5'd5, 32'h100, 32'hDEADBEEF, 0), st);
        check("lw stalls", 32'(st), 32'd0);
        check("lw ReadData", ReadData_out, 32'hDEADBEEF);
        check("lw RegWrite", 32'(Ctl_RegWrite_out), 32'h1);

        issue(mk_load(3'b000, 5'd6, 32'h103, 32'h80FF_FFFF, 3), st);
        check("lb stalls", 32'(st), 32'd3);
        check("lb ReadData", ReadData_out, 32'hFFFF_FF80);
        issue(mk_load(3'b100, 5'd6, 32'h103, 32'h80FF_FFFF, 3), st);
        check("lbu ReadData", ReadData_out, 32'h0000_0080);

        issue(mk_store(3'b001, 32'h202, 32'h1234ABCD, 0), st);
        check("sh we", 32'(obs_we), 32'h1);
        check("sh be", 32'(obs_be), 32'hC);
        check("sh wdata", obs_wdata, 32'hABCDABCD);
        issue(mk_store(3'b001, 32'h201, 32'h1234ABCD, 0), st);
        check("sh misaligned req", 32'(obs_req), 32'h0);
        check("sh misaligned err", 32'(misalign_err_out), 32'h1);
        check("sh misaligned RegWrite", 32'(Ctl_RegWrite_out), 32'h0);
        issue(mk_load(3'b011, 5'd7, 32'h300, 32'h0, 0), st);
        check("illegal funct3 err", 32'(misalign_err_out), 32'h1);
        check("illegal funct3 RegWrite", 32'(Ctl_RegWrite_out), 32'h0);
        issue(mk_store(3'b000, 32'h3, 32'h0000_00A5, 1), st);
        check("sb be", 32'(obs_be), 32'h8);
        check("sb wdata", obs_wdata, 32'hA5A5A5A5);
        check("sb err cleared", 32'(misalign_err_out), 32'h0);

        issue(mk_store(3'b010, 32'h404, 32'h0BAD_F00D, TIMEOUT), st);
        check("sw late-ack stalls", 32'(st), 32'd16);
        check("sw late-ack bus_err", 32'(bus_err_out), 32'h0);
        issue(mk_load(3'b010, 5'd8, 32'h400, 32'h1111_1111, -1), st);
        check("timeout stalls", 32'(st), 32'd16);
        check("timeout bus_err", 32'(bus_err_out), 32'h1);
        check("timeout RegWrite", 32'(Ctl_RegWrite_out), 32'h0);
        t = nop_i(); t.rw = 1; t.rd = 5'd7; t.alu = 32'h55;
        issue(t, st);
        check("bus_err sticky", 32'(bus_err_out), 32'h1);
        check("alu op RegWrite", 32'(Ctl_RegWrite_out), 32'h1);

        t = nop_i(); t.br = 1; t.f3 = 3'b001; t.zero = 0; t.pcimm = 32'h40;
        issue(t, st);
        check("bne PCSrc", 32'(obs_pcsrc), 32'h1);
        check("bne target", obs_target, 32'h40);
        t = nop_i(); t.br = 1; t.f3 = 3'b000; t.zero = 0; t.pcimm = 32'h40;
        issue(t, st);
        check("beq not-taken PCSrc", 32'(obs_pcsrc), 32'h0);
        t = nop_i(); t.jalr = 1; t.rw = 1; t.rd = 5'd1; t.alu = 32'h81; t.pc = 32'h10;
        issue(t, st);
        check("jalr target", obs_target, 32'h80);
        check("jalr link", ALUresult_out, 32'h14);
        t = nop_i(); t.jal = 1; t.rw = 1; t.rd = 5'd1; t.pc = 32'hFFFF_FFFC; t.pcimm = 32'h200;
        issue(t, st);
        check("jal link wrap", ALUresult_out, 32'h0);

        drive(mk_load(3'b010, 5'd9, 32'h300, 32'h0, 0));
        bus.ack = 1'b0;
        @(negedge clk);
        check("pre-reset req", 32'(bus.req), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre-reset busy stall", 32'(stall_out), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid-reset req", 32'(bus.req), 32'h0);
        check("mid-reset stall", 32'(stall_out), 32'h0);
        @(posedge clk);
        #1;
        check("post-reset RegWrite", 32'(Ctl_RegWrite_out), 32'h0);
        check("post-reset Rd", 32'(Rd_out), 32'h0);
        check("post-reset ALUresult", ALUresult_out, 32'h0);
        check("post-reset bus_err", 32'(bus_err_out), 32'h0);
        reset = 1'b1;
        drive(nop_i());
        bus.rdata = 32'hFFFF_FFFF;
        bus.ack = 1'b1;
        @(negedge clk);
        check("late ack req", 32'(bus.req), 32'h0);
        check("late ack stall", 32'(stall_out), 32'h0);
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
        check("late ack ReadData", ReadData_out, 32'h0);
        check("late ack RegWrite", 32'(Ctl_RegWrite_out), 32'h0);
        exp_rw = 0; exp_m2r = 0; exp_rd = 0; exp_alu = 0; exp_rdata = 0; exp_mis = 0; exp_buserr = 0;

        issue(mk_load(3'b001, 5'd10, 32'h2, 32'h8001_1234, 1), st);
        check("lh stalls", 32'(st), 32'd1);
        check("lh ReadData", ReadData_out, 32'hFFFF_8001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
